// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit.
// Every bit lasts Prescale clocks so it shares one oversampled clock with the receiver.
module uart_tx_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int Prescale_width = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [Prescale_width-1:0] Prescale,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]             BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [Prescale_width-1:0] PRESC_ONE = Prescale_width'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_q, state_d;
  logic [Prescale_width-1:0] edge_cnt_q, edge_cnt_d;
  logic [Prescale_width-1:0] presc_q, presc_d;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic                      par_en_q, par_en_d;
  logic                      par_bit_q, par_bit_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      bit_done;

  assign bit_done = (edge_cnt_q == presc_q - PRESC_ONE);

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    presc_d    = presc_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    if (state_q == IDLE) begin
      tx_d       = 1'b1;
      busy_d     = 1'b0;
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
      if (Data_Valid) begin
        state_d   = START;
        tx_d      = 1'b0;
        busy_d    = 1'b1;
        shift_d   = P_DATA;
        par_en_d  = PAR_EN;
        // Even parity is the XOR of the data; odd parity is its complement.
        par_bit_d = (^P_DATA) ^ PAR_TYP;
        presc_d   = (Prescale == '0) ? PRESC_ONE : Prescale;
      end
    end else if (!bit_done) begin
      edge_cnt_d = edge_cnt_q + PRESC_ONE;
    end else begin
      edge_cnt_d = '0;
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
        DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_d[0];
          end
        end
        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
        STOP: begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      presc_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      presc_q    <= presc_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: hand-written frame patterns checked bit by bit.
module tb_uart_tx_serializer;

  logic       clk;
  logic       reset_n;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  uart_tx_serializer #(.DATA_WIDTH(8), .Prescale_width(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge. pattern holds the frame bits in time order, first bit at
  // position nbits-1. Checks each bit at its first and last clock, then the idle after it.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic pe,
                           input logic pt, input logic [5:0] presc, input logic [15:0] pattern,
                           input int nbits, input bit hold, input int inject_at);
    int p;
    int len;
    int k;
    int r;
    p   = (presc == 0) ? 1 : int'(presc);
    len = nbits * p;
    P_DATA = data; PAR_EN = pe; PAR_TYP = pt; Prescale = presc; Data_Valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      Data_Valid = 1'b0;
      P_DATA = ~data; PAR_EN = ~pe; PAR_TYP = ~pt; Prescale = presc + 6'd3;
    end
    for (int j = 1; j <= len; j++) begin
      k = (j - 1) / p;
      r = (j - 1) % p;
      if (r == 0) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (r == 0 || r == p - 1)
        check($sformatf("%s_bit%0d", tag, k), 32'(TX_OUT), 32'(pattern[nbits-1-k]));
      if (inject_at != 0 && j == inject_at) begin
        Data_Valid = 1'b1;
        P_DATA = 8'h3C;
      end
      if (inject_at != 0 && j == inject_at + 1) Data_Valid = 1'b0;
      @(negedge clk);
    end
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_tx"}, 32'(TX_OUT), 32'd1);
    $display("frame %s data=%02h pe=%0d pt=%0d presc=%0d bits=%0d", tag, data, pe, pt, presc, nbits);
  endtask

  initial begin
    reset_n = 1'b0; Prescale = 6'd8; P_DATA = 8'h00; Data_Valid = 1'b0;
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(TX_OUT), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    // Idle line stays high while non-request inputs wiggle.
    for (int i = 0; i < 6; i++) begin
      P_DATA = 8'(i * 37); PAR_EN = i[0]; PAR_TYP = i[1]; Prescale = 6'(i);
      @(negedge clk);
    end
    check("idle_tx", 32'(TX_OUT), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 6'd8, 16'b01010010101, 11, 1'b0, 0);
    run_frame("01_even", 8'h01, 1'b1, 1'b0, 6'd8, 16'b01000000011, 11, 1'b0, 0);
    run_frame("01_odd",  8'h01, 1'b1, 1'b1, 6'd8, 16'b01000000001, 11, 1'b0, 0);
    run_frame("ff_nopar", 8'hFF, 1'b0, 1'b0, 6'd4, 16'b0111111111, 10, 1'b0, 0);
    run_frame("presc0", 8'h01, 1'b0, 1'b0, 6'd0, 16'b0100000001, 10, 1'b0, 0);

    // Request pulsed mid-frame must be dropped.
    run_frame("5a_inject", 8'h5A, 1'b1, 1'b0, 6'd8, 16'b00101101001, 11, 1'b0, 20);
    repeat (20) @(negedge clk);
    check("inject_idle_tx", 32'(TX_OUT), 32'd1);
    check("inject_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a data bit that is low.
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd8; Data_Valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Data_Valid = 1'b0;
    repeat (35) @(negedge clk);
    check("rstmid_pre_tx", 32'(TX_OUT), 32'd0);
    check("rstmid_pre_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_tx", 32'(TX_OUT), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rstmid_after_tx", 32'(TX_OUT), 32'd1);
    check("rstmid_after_busy", 32'(busy), 32'd0);
    run_frame("81_after_rst", 8'h81, 1'b0, 1'b0, 6'd4, 16'b0100000011, 10, 1'b0, 0);

    // Data_Valid held high: frames follow with one idle clock between them.
    run_frame("b2b_0", 8'h5A, 1'b0, 1'b0, 6'd4, 16'b0010110101, 10, 1'b1, 0);
    run_frame("b2b_1", 8'h5A, 1'b0, 1'b0, 6'd4, 16'b0010110101, 10, 1'b1, 0);
    run_frame("b2b_2", 8'h5A, 1'b0, 1'b0, 6'd4, 16'b0010110101, 10, 1'b1, 0);
    Data_Valid = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b_idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
